// File: rtl/rtype_encoder_loader.sv
// R-type instruction encoder and instruction-memory preloader.
// Turns {op, rd, rs1, rs2} requests into RV32I R-type words and writes
// them to consecutive word addresses starting at BASE_ADDR. A session
// opens with a start pulse and closes on an in_last accept or when the
// top word address has been written.
module rtype_encoder_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic                  in_last,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  full_err,
    output logic [ADDR_WIDTH:0]   count
);

    // Pointer carries one extra bit so "one past the top address" is
    // representable without wrapping back to zero.
    localparam logic [ADDR_WIDTH:0] BASE_PTR = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH+1)'((2 ** ADDR_WIDTH) - 1);
    localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH+1)'(1);
    localparam logic [6:0]          OPCODE_R = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q,      state_d;
    logic [ADDR_WIDTH:0]   ptr_q,        ptr_d;
    logic                  in_ready_q,   in_ready_d;
    logic                  imem_we_q,    imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q,  imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  busy_q,       busy_d;
    logic                  done_q,       done_d;
    logic                  full_err_q,   full_err_d;
    logic [ADDR_WIDTH:0]   count_q,      count_d;
    logic                  accept;

    // Same 3-bit ALU op code the decoder emits, mapped back to funct3/funct7.
    function automatic logic [31:0] encode(input logic [2:0] e_op,
                                           input logic [4:0] e_rd,
                                           input logic [4:0] e_rs1,
                                           input logic [4:0] e_rs2);
        logic [2:0] funct3;
        logic [6:0] funct7;
        funct7 = 7'b0000000;
        case (e_op)
            3'b000:  funct3 = 3'd0;               // ADD
            3'b001:  begin                        // SUB
                funct3 = 3'd0;
                funct7 = 7'b0100000;
            end
            3'b010:  funct3 = 3'd6;               // OR
            3'b011:  funct3 = 3'd7;               // AND
            3'b100:  funct3 = 3'd1;               // SLL
            3'b101:  funct3 = 3'd5;               // SRL
            3'b110:  funct3 = 3'd4;               // XOR
            default: funct3 = 3'd2;               // SLT
        endcase
        return {funct7, e_rs2, e_rs1, funct3, e_rd, OPCODE_R};
    endfunction

    // Next-state and next-output computation for the whole session FSM.
    always_comb begin
        // NOTE: every _d gets a default up front so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        ptr_d        = ptr_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        done_d       = 1'b0;
        full_err_d   = full_err_q;
        count_d      = count_q;
        accept       = in_valid && in_ready_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    ptr_d      = BASE_PTR;
                    count_d    = '0;
                    full_err_d = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = ptr_q[ADDR_WIDTH-1:0];
                    imem_wdata_d = encode(op, rd, rs1, rs2);
                    ptr_d        = ptr_q + ONE;
                    count_d      = count_q + ONE;
                    if (in_last) begin
                        state_d = DONE;
                    end else if (ptr_q == LAST_PTR) begin
                        // Ran out of address space before the host said last.
                        state_d    = DONE;
                        full_err_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == LOAD) && (ptr_d <= LAST_PTR);
        busy_d     = (state_d == LOAD);
    end

    // Single state register for the FSM and all of its registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= BASE_PTR;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_PTR[ADDR_WIDTH-1:0];
            imem_wdata_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            full_err_q   <= 1'b0;
            count_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge values; blocking would let later flops see new ones.
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            full_err_q   <= full_err_d;
            count_q      <= count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign full_err   = full_err_q;
    assign count      = count_q;

endmodule
